// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock-divider bank: mode encodings
// and the width helper for the channel-select field.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // A single-channel bank still needs a 1-bit select so the port exists.
    function automatic int cfg_ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter, active/shadow divide config,
// boundary-only apply of the shadow, and a registered divided clock or tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int WIDTH        = 25,
    parameter int DEFAULT_DIV  = 25000,
    parameter bit DEFAULT_MODE = MODE_TOGGLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_mode,
    output logic             out_clk,
    output logic             pend
);

    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic             DEF_MODE = DEFAULT_MODE;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_div;
    logic [WIDTH-1:0] sh_div;
    logic             act_mode;
    logic             sh_mode;
    logic             run;
    logic             terminal;
    logic             apply;
    logic             mode_change;

    // sync, a disabled channel and an idle (D=0) channel all collapse to "not
    // running"; each of those is also a safe point to take the shadow config.
    always_comb begin
        run         = en && !sync && (act_div != '0);
        terminal    = run && (cnt == (act_div - ONE));
        apply       = pend && (!run || terminal);
        mode_change = apply && (sh_mode != act_mode);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_div  <= DEF_DIV;
            act_mode <= DEF_MODE;
            sh_div   <= DEF_DIV;
            sh_mode  <= DEF_MODE;
            pend     <= 1'b0;
        end else begin
            if (apply) begin
                act_div  <= sh_div;
                act_mode <= sh_mode;
            end
            // A write landing on an apply edge survives as the next pending value.
            if (we) begin
                sh_div  <= wr_div;
                sh_mode <= wr_mode;
                pend    <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            out_clk <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            out_clk <= 1'b0;
        end else begin
            cnt <= terminal ? '0 : (cnt + ONE);
            if (mode_change)
                out_clk <= 1'b0;
            else if (act_mode == MODE_PULSE)
                out_clk <= terminal;
            else
                out_clk <= out_clk ^ terminal;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable dividers sharing one system clock,
// with a single config port decoded into per-channel shadow writes.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int WIDTH        = 25,
    parameter int DEFAULT_DIV  = 25000,
    parameter bit DEFAULT_MODE = MODE_TOGGLE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               en,
    input  logic                          sync,
    input  logic                          cfg_we,
    input  logic [cfg_ch_width(N_CH)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]              cfg_div,
    input  logic                          cfg_mode,
    output logic [N_CH-1:0]               out_clk,
    output logic [N_CH-1:0]               pend
);

    logic [N_CH-1:0] ch_we;

    // Out-of-range channel numbers match no strobe, so such writes vanish.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_we && (int'(cfg_ch) == i))
                ch_we[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .WIDTH        (WIDTH),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .we      (ch_we[g]),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .out_clk (out_clk[g]),
            .pend    (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scenario bench for clk_div_bank: expected outputs come from closed-form
// event timing, are queued when stimulus is driven and popped after the edge.
module tb_clk_div_bank;

    localparam int N_CH        = 3;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 3;

    typedef struct {
        logic [N_CH-1:0] out;
        logic [N_CH-1:0] pend;
        logic [N_CH-1:0] mask;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;
    logic [N_CH-1:0]  out_clk;
    logic [N_CH-1:0]  pend;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    clk_div_bank #(
        .N_CH         (N_CH),
        .WIDTH        (WIDTH),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .DEFAULT_MODE (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .out_clk  (out_clk),
        .pend     (pend)
    );

    // Toggle output after edge k when events fall at start+d, start+2d, ...
    function automatic logic tog_at(input int k, input int start, input int d);
        return (((k - start) / d) % 2) == 1;
    endfunction

    // Pulse output after edge k: high only on the event edges.
    function automatic logic pul_at(input int k, input int start, input int d);
        return (k > start) && (((k - start) % d) == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic we, input logic [1:0] ch,
                             input logic [WIDTH-1:0] d, input logic m);
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_div  = d;
        cfg_mode = m;
    endtask

    // Leaves the bench #1 after an edge so the following edge is "edge 1".
    task automatic do_reset(input logic [N_CH-1:0] en_init);
        rst  = 1'b1;
        en   = en_init;
        sync = 1'b0;
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst  = 1'b0;
        en   = '1;
        sync = 1'b0;
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
        #1;
        rst = 1'b1;
        e = '{out: '0, pend: '0, mask: '1};
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        checks++;
        if (out_clk !== e.out || pend !== e.pend)
            $display("[TB] FAIL reset_hold: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                     out_clk, pend, e.out, e.pend);
        else passes++;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            for (int c = 0; c < N_CH; c++) e.out[c] = tog_at(k, 0, 3);
            e.pend = '0;
            e.mask = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL reset_toggle edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
    endtask

    task automatic test_pulse_reprogram();
        exp_t e;
        do_reset('1);
        for (int k = 1; k <= 16; k++) begin
            drive_cfg(k == 2, 2'd1, 8'd4, 1'b1);
            e.out[0] = tog_at(k, 0, 3);
            e.out[2] = tog_at(k, 0, 3);
            e.out[1] = (k <= 3) ? tog_at(k, 0, 3) && (k != 3) : pul_at(k, 3, 4);
            e.pend   = (k == 2) ? 3'b010 : 3'b000;
            e.mask   = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL pulse_reprogram edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic test_collision();
        exp_t e;
        do_reset('1);
        for (int k = 1; k <= 18; k++) begin
            drive_cfg((k == 1) || (k == 3), 2'd0, (k == 1) ? 8'd4 : 8'd5, 1'b0);
            e.out[0] = (k >= 3 && k < 7) || (k >= 12 && k < 17);
            e.out[1] = tog_at(k, 0, 3);
            e.out[2] = tog_at(k, 0, 3);
            e.pend   = (k <= 6) ? 3'b001 : 3'b000;
            e.mask   = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL write_collision edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic test_sync();
        exp_t e;
        do_reset('1);
        for (int k = 1; k <= 26; k++) begin
            if (k == 1)      drive_cfg(1'b1, 2'd0, 8'd3, 1'b1);
            else if (k == 2) drive_cfg(1'b1, 2'd1, 8'd6, 1'b1);
            else             drive_cfg(1'b0, 2'd0, '0, 1'b0);
            sync = (k == 12);
            if (k >= 12) begin
                e.out[0] = pul_at(k, 12, 3);
                e.out[1] = pul_at(k, 12, 6);
                e.out[2] = tog_at(k, 12, 3);
                e.pend   = '0;
                e.mask   = '1;
                sb.push_back(e);
            end
            tick();
            if (k >= 12) begin
                e = sb.pop_front();
                checks++;
                if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                    $display("[TB] FAIL sync_align edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                             k, out_clk, pend, e.out, e.pend);
                else passes++;
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_edge_values();
        exp_t e;
        do_reset(3'b011);
        for (int k = 1; k <= 14; k++) begin
            en = (k >= 3) ? 3'b111 : 3'b011;
            if (k == 1)      drive_cfg(1'b1, 2'd2, 8'd0, 1'b0);
            else if (k == 2) drive_cfg(1'b1, 2'd1, 8'd1, 1'b1);
            else if (k == 4) drive_cfg(1'b1, 2'd3, 8'd7, 1'b1);
            else             drive_cfg(1'b0, 2'd0, '0, 1'b0);
            e.out[0] = tog_at(k, 0, 3);
            e.out[1] = (k >= 4);
            e.out[2] = 1'b0;
            e.pend   = (k == 1) ? 3'b100 : (k == 2) ? 3'b010 : 3'b000;
            e.mask   = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL edge_values edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic test_max_div();
        exp_t e;
        do_reset('1);
        for (int k = 1; k <= 520; k++) begin
            drive_cfg(k == 1, 2'd0, 8'd255, 1'b1);
            e.out[0] = (k <= 3) ? 1'b0 : pul_at(k, 3, 255);
            e.out[1] = tog_at(k, 0, 3);
            e.out[2] = tog_at(k, 0, 3);
            e.pend   = (k <= 2) ? 3'b001 : 3'b000;
            e.mask   = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL max_div_wrap edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic test_enable();
        exp_t e;
        do_reset('1);
        for (int k = 1; k <= 18; k++) begin
            en = (k >= 5 && k <= 7) ? 3'b110 : 3'b111;
            drive_cfg(k == 4, 2'd0, 8'd4, 1'b0);
            e.out[0] = (k >= 3 && k <= 4) || (k >= 11 && k <= 14);
            e.out[1] = tog_at(k, 0, 3);
            e.out[2] = tog_at(k, 0, 3);
            e.pend   = (k == 4) ? 3'b001 : 3'b000;
            e.mask   = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL enable_restart edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
        en = '1;
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset('1);
        for (int k = 1; k <= 4; k++) begin
            drive_cfg(k == 4, 2'd1, 8'd5, 1'b1);
            e.out  = {N_CH{tog_at(k, 0, 3)}};
            e.pend = (k == 4) ? 3'b010 : 3'b000;
            e.mask = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL reset_mid_pre edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
        drive_cfg(1'b0, 2'd0, '0, 1'b0);
        #3;
        rst = 1'b1;
        e = '{out: '0, pend: '0, mask: '1};
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        if (out_clk !== e.out || pend !== e.pend)
            $display("[TB] FAIL reset_mid_async: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                     out_clk, pend, e.out, e.pend);
        else passes++;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            e.out  = {N_CH{tog_at(k, 0, 3)}};
            e.pend = '0;
            e.mask = '1;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ((out_clk & e.mask) !== (e.out & e.mask) || pend !== e.pend)
                $display("[TB] FAIL reset_mid_defaults edge %0d: out_clk=%b pend=%b, expected out_clk=%b pend=%b",
                         k, out_clk, pend, e.out, e.pend);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_pulse_reprogram();
        test_collision();
        test_sync();
        test_edge_values();
        test_max_div();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of N_CH independent programmable clock dividers, each running from the single system clock. Each channel outputs either a 50 %-duty toggled divided clock or a one-cycle tick. Divide values are reprogrammable at run time through a shadow register that takes effect only at a period boundary, so reprogramming never produces a glitch. The bank replaces fixed-constant dividers wherever the design needs display-scan, debounce or timer rates.

## Interface
- N_CH, 4: number of divider channels (1..16).
- WIDTH, 25: counter and divide-value width.
- DEFAULT_DIV, 25000: active and shadow divide value of every channel after reset.
- DEFAULT_MODE, 0: mode after reset; 0 = toggle, 1 = pulse.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  N_CH  per-channel run enable.
- sync  in  1  one-cycle strobe that restarts all channels in phase.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel; writes with cfg_ch ≥ N_CH are ignored.
- cfg_div  in  WIDTH  new divide value D.
- cfg_mode  in  1  new mode.
- out_clk  out  N_CH  divided clock (toggle) or tick (pulse), registered.
- pend  out  N_CH  shadow config written but not yet applied.

## Operation
- Each channel holds cnt[WIDTH-1:0], active {div, mode}, shadow {div, mode} and pend.
- Reset: cnt = 0, out_clk = 0, pend = 0, active = shadow = {DEFAULT_DIV, DEFAULT_MODE}.
- Run (en = 1, active div = D ≥ 1):
  - cnt increments each cycle.
  - When cnt == D-1 this is a terminal event: cnt wraps to 0.
  - Toggle mode: out_clk inverts on the event.
  - Pulse mode: out_clk = 1 for exactly the one cycle after the event, 0 otherwise.
- D = 0: the channel is idle. cnt is held at 0 and out_clk = 0. A pending shadow is still applied on the next cycle.
- D = 1: in pulse mode out_clk is constantly 1; in toggle mode it is clk/2.
- Config write: {cfg_div, cfg_mode} goes to shadow[cfg_ch] and pend is set. A later write before apply overwrites the shadow; the last write wins.
- Apply (shadow → active, pend cleared) happens at the first of:
  - a terminal event;
  - en = 0;
  - sync;
  - active D = 0.
- Write in the same cycle as an apply: the apply copies the old shadow, the new value lands in shadow, and pend stays 1.
- Mode change at apply: out_clk is forced to 0 in the same edge.
- en = 0: cnt = 0 and out_clk = 0 on the next edge; the channel resumes from cnt = 0 when en returns.
- sync: every channel gets cnt = 0 and out_clk = 0 and applies any pending shadow. sync has priority over a terminal event in the same cycle.

## Timing
- With en high from the first edge after reset release (edge 1), events occur at edges D, 2D, 3D, …
- Toggle mode: out_clk rises after edge D, falls after 2D; period 2D.
- Pulse mode: one high cycle every D cycles.
- Outputs are registered with no combinational path from any input.
- en, sync and cfg take effect at the next edge.
- Asynchronous rst overrides everything mid-period. Pending config is discarded and defaults are restored.

## Structure
- Package clk_div_pkg holds:
  - MODE_TOGGLE = 1'b0 and MODE_PULSE = 1'b1;
  - a function giving the cfg_ch width (minimum 1).
- Sub-module clk_div_ch implements one channel: counter, active/shadow registers, apply logic and output register.
- clk_div_bank generates N_CH instances and decodes cfg_ch into per-channel write strobes.

## Test plan
- Reset defaults, WIDTH=8, DEFAULT_DIV=3, toggle mode, en=1: out_clk rises after edge 3, falls after edge 6, period 6; pend=0.
- Pulse mode reprogram: write D=4, mode=1 mid-period on channel 1 → pend[1]=1 until the next event, then pend[1]=0 and out_clk[1] is high 1 cycle in every 4.
- Write colliding with an event: write D=5 in the exact event cycle → the old shadow is applied, pend stays 1, and D=5 takes effect at the following event.
- Sync alignment: channels with D=3 and D=6 in free-running phase, pulse sync → both cnt=0 and out_clk=0 next cycle, then events at sync+3 (ch0) and sync+6 (ch1).
- Edge values:
  - D=0 → out_clk stays 0;
  - D=1 in pulse mode → out_clk constantly 1;
  - D=2^WIDTH-1 → the wrap is exact;
  - cfg_ch=N_CH → no state change.
- Enable and reset interplay:
  - en dropped mid-count → out_clk=0 next cycle, and the restart gives its first event D cycles after en rises;
  - rst asserted mid-period with pend set → all defaults restored and pend=0.
